cpu_trace_buffer: RTL
=====================

# cpu_trace_buffer

- Downstream consumer of the 16-bit simplified MIPS CPU.
- Captures one trace record {PC, IR, ALUOut} per retired instruction into a small FIFO and drains it over a valid/ready port to a logger or bench scoreboard.
- Detects the halt instruction (IR = 16'hFFFF), counts retired instructions and asserts `halted` once every record, including the halt record, has been drained.

## Interface

Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `HALT_IR`, 16'hFFFF: instruction word that ends a run.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `retire`  in  1  CPU retires the instruction on `pc`/`ir`/`alu_out` this cycle.
- `pc`  in  16  PC of the retiring instruction.
- `ir`  in  16  instruction word.
- `alu_out`  in  16  signed result/write-data.
- `out_valid`  out  1  head record available.
- `out_ready`  in  1  consumer accepts the head record.
- `out_pc`, `out_ir`, `out_alu`  out  16 each  head record fields.
- `level`  out  $clog2(DEPTH+1)  current occupancy.
- `instr_count`  out  16  retired instructions, including halt; saturates at 16'hFFFF.
- `overflow`  out  1  sticky: at least one record was dropped.
- `halted`  out  1  halt seen and FIFO fully drained.

## Operation

- Reset (asynchronous, on `reset_n` = 0):
  - state RUN; pointers, `level`, `instr_count` = 0.
  - `overflow`, `halted`, `out_valid` = 0.
  - `out_*` = 0.
- States RUN → DRAIN → DONE:
  - RUN: each `retire` = 1 pushes a record and increments `instr_count`. A retire with `ir` == `HALT_IR` still pushes, then the state moves to DRAIN.
  - DRAIN: `retire` is ignored; `instr_count` is frozen. When `level` == 0, move to DONE.
  - DONE: `halted` = 1 and stays set until reset; `retire` is ignored.
- Pop: occurs when `out_valid` && `out_ready`; the head pointer advances.
- Push when full:
  - Without a same-cycle pop: record dropped, `overflow` set (sticky), `instr_count` still increments.
  - With a same-cycle pop: push accepted, `level` unchanged.
- Push and pop in the same cycle, not full: both happen; `level` unchanged.
- Pointers wrap modulo `DEPTH`. `level` is an explicit counter, not derived from pointers.
- `out_*` show the head entry whenever `out_valid` = 1. The values are unspecified (but stable) when `out_valid` = 0.
- A halt retired while the FIFO is full is dropped like any other record. DRAIN is still entered and `overflow` is set.
- Reset asserted mid-run or mid-drain clears everything immediately; contents are discarded.

## Timing

- Push latency:
  - A record pushed at edge N appears on `out_*` with `out_valid` = 1 after edge N when the FIFO was empty.
  - Otherwise it appears after all earlier records pop.
- There is no combinational path from `retire`/`pc`/`ir` to any output.
- `out_ready` → `out_valid` has no combinational path. `out_valid` is a function of `level` only.
- `halted` rises at the edge after the one where the last record pops, i.e. one cycle in DRAIN with `level` == 0.
- Halt retired into an empty FIFO with `out_ready` held at 1: the halt record pops at the next edge, and `halted` = 1 one edge later.

## Structure

- Package `cpu_trace_pkg`:
  - `HALT_IR_DEFAULT` = 16'hFFFF.
  - `trace_state_t` enum {RUN, DRAIN, DONE}.
  - `trace_rec_t` packed struct {pc, ir, alu}, 48 bits.
- Sub-module `trace_fifo`:
  - Parameterised by `DEPTH` and width 48.
  - Ports: push, pop, din, dout, level, full, empty.
- `cpu_trace_buffer` holds the FSM, counter, overflow flag and drop logic.

## Test plan

- Program replay: 10 retires with PCs 0,2,…,18, the last with IR 16'hFFFF, `out_ready` = 1.
  - Records emerge in order with exact PC/IR/ALU values, e.g. PC 12 → IR 16'h4740, ALU −32 (16'hFFE0).
  - `instr_count` = 10; `halted` = 1 two edges after the halt retire; `overflow` = 0.
- Backpressure: `out_ready` = 0 and 8 retires → `level` = 8. A 9th retire → dropped, `overflow` = 1, `instr_count` = 9. Then release `out_ready` → first 8 records emerge in order.
- Full with simultaneous push/pop: `level` = 8, retire with `out_ready` = 1 → `level` stays 8, `overflow` stays 0, and the new record appears last.
- Post-halt retires: retires after the halt → ignored; `instr_count` is unchanged and no extra records appear.
- Wrap-around: 20 retires with `out_ready` toggling every cycle → all 20 records emerge in order across pointer wraps; `level` never exceeds 8.
- Mid-drain reset: pull `reset_n` low with `level` = 5 in DRAIN. Outputs go to reset values immediately. After release, a new run behaves as after power-up.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU retire-trace buffer.
// A trace record is the {PC, IR, ALUOut} triple of one retired instruction.
package cpu_trace_pkg;

    localparam logic [15:0] HALT_IR_DEFAULT = 16'hFFFF;
    localparam int          REC_W           = 48;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } trace_state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] alu;
    } trace_rec_t;

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular-buffer FIFO with an explicit occupancy counter.
// A push while full is taken only when a pop frees a slot in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 48
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (do_push) tail <= tail + AW'(1);
            if (do_pop)  head <= head + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[tail] <= din;
    end

    // Storage is not reset, so an empty FIFO presents zeros instead of stale data.
    assign dout = empty ? '0 : mem[head];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures one record per retired CPU instruction and drains it over valid/ready.
// Stops accepting at the halt instruction and reports halted once fully drained.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter logic [15:0] HALT_IR = HALT_IR_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       retire,
    input  logic [15:0]                pc,
    input  logic [15:0]                ir,
    input  logic [15:0]                alu_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_pc,
    output logic [15:0]                out_ir,
    output logic [15:0]                out_alu,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [15:0]                instr_count,
    output logic                       overflow,
    output logic                       halted
);

    localparam int LW = $clog2(DEPTH+1);

    trace_state_t state;
    trace_state_t state_next;
    trace_rec_t   rec_in;
    trace_rec_t   rec_out;
    logic         fifo_full;
    logic         fifo_empty;
    logic         accept;
    logic         pop;
    logic         push;
    logic         drop;

    // Handshake: the head record transfers on any rising edge where out_valid
    // and out_ready are both 1; out_valid depends only on occupancy, never on out_ready.
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    assign accept = retire && (state == RUN);
    assign push   = accept && (!fifo_full || pop);
    assign drop   = accept && fifo_full && !pop;

    assign rec_in = '{pc: pc, ir: ir, alu: alu_out};

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (rec_in),
        .dout    (rec_out),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_pc  = rec_out.pc;
    assign out_ir  = rec_out.ir;
    assign out_alu = rec_out.alu;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                // A dropped halt still ends the run.
                if (accept && (ir == HALT_IR)) state_next = DRAIN;
            end
            DRAIN: begin
                if (level == '0) state_next = DONE;
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign halted = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (accept) instr_count <= sat_inc16(instr_count);
            if (drop)   overflow    <= 1'b1;
        end
    end

    a_level_bound: assert property (@(posedge clock) disable iff (!reset_n)
        level <= LW'(DEPTH));

    a_halted_empty: assert property (@(posedge clock) disable iff (!reset_n)
        halted |-> !out_valid);

    a_head_stable: assert property (@(posedge clock) disable iff (!reset_n)
        (out_valid && !out_ready) |=> (out_valid && $stable({out_pc, out_ir, out_alu})));

endmodule
